// File: rtl/bus_arbiter_pkg.sv
// Shared types for the two-master bus arbiter: FSM states,
// captured request bundle, bhw codes and the timeout read value.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam logic [2:0] BHW_BYTE = 3'd0;
    localparam logic [2:0] BHW_HALF = 3'd1;
    localparam logic [2:0] BHW_WORD = 3'd2;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  bhw;
        logic        wnr;
    } bus_req_t;

endpackage

// File: rtl/bus_arbiter_req_latch.sv
// Per-master request capture: holds one outstanding request.
// Ports: i_dv/i_req capture, i_clr retire, o_pending/o_req, sticky o_protocol_err.
module bus_arbiter_req_latch
    import bus_arbiter_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  logic     i_dv,
    input  bus_req_t i_req,
    input  logic     i_clr,
    output logic     o_pending,
    output bus_req_t o_req,
    output logic     o_protocol_err
);

    logic     pending_q, pending_d;
    bus_req_t req_q, req_d;
    logic     err_q, err_d;

    // A pulse while still pending is dropped; the pending flag is
    // checked before this edge's retire, so a pulse in the response
    // cycle (flag already clear) is a legal new request.
    always_comb begin
        pending_d = pending_q;
        req_d     = req_q;
        err_d     = err_q;
        if (i_clr) begin
            pending_d = 1'b0;
        end
        if (i_dv) begin
            if (pending_q) begin
                err_d = 1'b1;
            end else begin
                pending_d = 1'b1;
                req_d     = i_req;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending_q <= 1'b0;
            req_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            req_q     <= req_d;
            err_q     <= err_d;
        end
    end

    assign o_pending      = pending_q;
    assign o_req          = req_q;
    assign o_protocol_err = err_q;

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with slave watchdog.
// Ports: i_mX_* requests, o_mX_* responses, o_bus_*/i_bus_* slave side, status flags.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_m0_DV,
    input  logic [31:0] i_m0_address,
    input  logic [31:0] i_m0_data,
    input  logic [2:0]  i_m0_bhw,
    input  logic        i_m0_write_notread,
    output logic [31:0] o_m0_data,
    output logic        o_m0_DV,
    output logic        o_m0_timeout,
    input  logic        i_m1_DV,
    input  logic [31:0] i_m1_address,
    input  logic [31:0] i_m1_data,
    input  logic [2:0]  i_m1_bhw,
    input  logic        i_m1_write_notread,
    output logic [31:0] o_m1_data,
    output logic        o_m1_DV,
    output logic        o_m1_timeout,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_data,
    output logic [2:0]  o_bus_bhw,
    output logic        o_bus_write_notread,
    output logic        o_bus_DV,
    input  logic [31:0] i_bus_data,
    input  logic        i_bus_DV,
    output logic        o_owner,
    output logic        o_busy,
    output logic        o_protocol_err,
    output logic        o_stray_resp
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0] pending;
    logic [1:0] clr;
    logic [1:0] perr;
    bus_req_t   req0, req1;

    bus_arbiter_req_latch u_m0 (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_dv           (i_m0_DV),
        .i_req          ({i_m0_address, i_m0_data,
                          i_m0_bhw, i_m0_write_notread}),
        .i_clr          (clr[0]),
        .o_pending      (pending[0]),
        .o_req          (req0),
        .o_protocol_err (perr[0])
    );

    bus_arbiter_req_latch u_m1 (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_dv           (i_m1_DV),
        .i_req          ({i_m1_address, i_m1_data,
                          i_m1_bhw, i_m1_write_notread}),
        .i_clr          (clr[1]),
        .o_pending      (pending[1]),
        .o_req          (req1),
        .o_protocol_err (perr[1])
    );

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [15:0]      cnt_q, cnt_d;
    bus_req_t         bus_q, bus_d;
    logic [1:0][31:0] rsp_data_q, rsp_data_d;
    logic [1:0]       rsp_dv_q, rsp_dv_d;
    logic [1:0]       rsp_to_q, rsp_to_d;
    logic             stray_q, stray_d;
    logic             grant;

    // Round-robin: on a tie the master not served last wins.
    assign grant = (&pending) ? ~last_q : pending[1];

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        bus_d      = bus_q;
        rsp_data_d = rsp_data_q;
        rsp_dv_d   = 2'b00;
        rsp_to_d   = 2'b00;
        clr        = 2'b00;
        stray_d    = stray_q | (i_bus_DV & (state_q != ST_WAIT));
        unique case (state_q)
            ST_IDLE: begin
                if (|pending) begin
                    owner_d = grant;
                    bus_d   = grant ? req1 : req0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_bus_DV) begin
                    rsp_data_d[owner_q] = i_bus_data;
                    rsp_dv_d[owner_q]   = 1'b1;
                    clr[owner_q]        = 1'b1;
                    last_d              = owner_q;
                    state_d             = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d[owner_q] = ERR_DATA;
                    rsp_dv_d[owner_q]   = 1'b1;
                    rsp_to_d[owner_q]   = 1'b1;
                    clr[owner_q]        = 1'b1;
                    state_d             = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            bus_q      <= '0;
            rsp_data_q <= '0;
            rsp_dv_q   <= 2'b00;
            rsp_to_q   <= 2'b00;
            stray_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            bus_q      <= bus_d;
            rsp_data_q <= rsp_data_d;
            rsp_dv_q   <= rsp_dv_d;
            rsp_to_q   <= rsp_to_d;
            stray_q    <= stray_d;
        end
    end

    assign o_m0_data           = rsp_data_q[0];
    assign o_m0_DV             = rsp_dv_q[0];
    assign o_m0_timeout        = rsp_to_q[0];
    assign o_m1_data           = rsp_data_q[1];
    assign o_m1_DV             = rsp_dv_q[1];
    assign o_m1_timeout        = rsp_to_q[1];
    assign o_bus_address       = bus_q.addr;
    assign o_bus_data          = bus_q.data;
    assign o_bus_bhw           = bus_q.bhw;
    assign o_bus_write_notread = bus_q.wnr;
    assign o_bus_DV            = (state_q == ST_ISSUE);
    assign o_owner             = owner_q;
    assign o_busy              = (state_q != ST_IDLE);
    assign o_protocol_err      = |perr;
    assign o_stray_resp        = stray_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic
// checked against a transaction-level arbitration model.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int T = 8;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic        i_rst_n;
    logic        i_m0_DV, i_m1_DV;
    logic [31:0] i_m0_address, i_m0_data, i_m1_address, i_m1_data;
    logic [2:0]  i_m0_bhw, i_m1_bhw;
    logic        i_m0_write_notread, i_m1_write_notread;
    logic [31:0] o_m0_data, o_m1_data;
    logic        o_m0_DV, o_m1_DV, o_m0_timeout, o_m1_timeout;
    logic [31:0] o_bus_address, o_bus_data, i_bus_data;
    logic [2:0]  o_bus_bhw;
    logic        o_bus_write_notread, o_bus_DV, i_bus_DV;
    logic        o_owner, o_busy, o_protocol_err, o_stray_resp;

    bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_m0_DV             (i_m0_DV),
        .i_m0_address        (i_m0_address),
        .i_m0_data           (i_m0_data),
        .i_m0_bhw            (i_m0_bhw),
        .i_m0_write_notread  (i_m0_write_notread),
        .o_m0_data           (o_m0_data),
        .o_m0_DV             (o_m0_DV),
        .o_m0_timeout        (o_m0_timeout),
        .i_m1_DV             (i_m1_DV),
        .i_m1_address        (i_m1_address),
        .i_m1_data           (i_m1_data),
        .i_m1_bhw            (i_m1_bhw),
        .i_m1_write_notread  (i_m1_write_notread),
        .o_m1_data           (o_m1_data),
        .o_m1_DV             (o_m1_DV),
        .o_m1_timeout        (o_m1_timeout),
        .o_bus_address       (o_bus_address),
        .o_bus_data          (o_bus_data),
        .o_bus_bhw           (o_bus_bhw),
        .o_bus_write_notread (o_bus_write_notread),
        .o_bus_DV            (o_bus_DV),
        .i_bus_data          (i_bus_data),
        .i_bus_DV            (i_bus_DV),
        .o_owner             (o_owner),
        .o_busy              (o_busy),
        .o_protocol_err      (o_protocol_err),
        .o_stray_resp        (o_stray_resp)
    );

    int checks = 0;
    int passed = 0;

    // model state: one pending request per master, in-flight txn
    bit          pend [2];
    int          cap  [2];
    logic [31:0] raddr[2];
    logic [31:0] rdata[2];
    logic [2:0]  rbhw [2];
    logic        rwnr [2];
    bit          last_g, act, own, exp_to, perr_m, stray_m, auto_sl;
    int          edge_n, iss_edge, exp_edge, k_cur, done_edge, dir_k;
    logic [31:0] exp_data, sl_data, dir_data;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        pend[0] = 0; pend[1] = 0;
        last_g = 1; act = 0; perr_m = 0; stray_m = 0;
    endtask

    task automatic req(input int m, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] b,
                       input logic w);
        if (m == 0) begin
            i_m0_DV = 1; i_m0_address = a; i_m0_data = d;
            i_m0_bhw = b; i_m0_write_notread = w;
        end else begin
            i_m1_DV = 1; i_m1_address = a; i_m1_data = d;
            i_m1_bhw = b; i_m1_write_notread = w;
        end
        if (pend[m]) begin
            perr_m = 1;
        end else begin
            pend[m] = 1; cap[m] = edge_n + 1;
            raddr[m] = a; rdata[m] = d; rbhw[m] = b; rwnr[m] = w;
        end
    endtask

    task automatic monitor();
        bit dv, to, e, c0, c1, eo;
        logic [31:0] d;
        int first;
        for (int m = 0; m < 2; m++) begin
            dv = (m == 1) ? o_m1_DV : o_m0_DV;
            to = (m == 1) ? o_m1_timeout : o_m0_timeout;
            d  = (m == 1) ? o_m1_data : o_m0_data;
            e  = act && (int'(own) == m) && (edge_n == exp_edge);
            if (dv || e) begin
                check($sformatf("m%0d_dv", m), 32'(dv), 32'(e));
                if (e) begin
                    check($sformatf("m%0d_data", m), d, exp_data);
                    check($sformatf("m%0d_timeout", m), 32'(to), 32'(exp_to));
                    act = 0; pend[m] = 0; done_edge = edge_n;
                    if (!exp_to) last_g = (m == 1);
                end
            end
        end
        if (act && edge_n > iss_edge)
            check("hold_addr", o_bus_address, raddr[own]);
        if (o_bus_DV) begin
            c0 = pend[0] && cap[0] <= edge_n - 1;
            c1 = pend[1] && cap[1] <= edge_n - 1;
            check("issue_idle", 32'(act), 0);
            check("issue_cand", 32'(c0 || c1), 1);
            eo = (c0 && c1) ? !last_g : c1;
            first = (c0 && c1) ? ((cap[0] < cap[1]) ? cap[0] : cap[1])
                               : (c1 ? cap[1] : cap[0]);
            if (done_edge > first) first = done_edge;
            check("issue_time", edge_n, first + 1);
            check("issue_owner", 32'(o_owner), 32'(eo));
            check("bus_addr", o_bus_address, raddr[eo]);
            check("bus_data", o_bus_data, rdata[eo]);
            check("bus_bhw", 32'(o_bus_bhw), 32'(rbhw[eo]));
            check("bus_wnr", 32'(o_bus_write_notread), 32'(rwnr[eo]));
            act = 1; own = eo; iss_edge = edge_n;
            k_cur   = auto_sl ? int'($urandom_range(0, 6)) : dir_k;
            sl_data = auto_sl ? $urandom : dir_data;
            if (k_cur >= 1 && k_cur <= T) begin
                exp_edge = edge_n + k_cur + 1; exp_to = 0; exp_data = sl_data;
            end else begin
                exp_edge = edge_n + T + 1; exp_to = 1; exp_data = 32'hDEADBEEF;
            end
        end
        if (act && !exp_to && edge_n == iss_edge + k_cur) begin
            i_bus_DV = 1; i_bus_data = sl_data;
            check("slv_addr", o_bus_address, raddr[own]);
            check("slv_data", o_bus_data, rdata[own]);
            check("slv_bhw", 32'(o_bus_bhw), 32'(rbhw[own]));
            check("slv_wnr", 32'(o_bus_write_notread), 32'(rwnr[own]));
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
        edge_n++;
        i_m0_DV = 0; i_m1_DV = 0; i_bus_DV = 0;
        monitor();
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((act || pend[0] || pend[1]) && n < bound) begin
            cyc(); n++;
        end
        check("drain", 32'(act || pend[0] || pend[1]), 0);
        repeat (3) cyc();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(o_busy), 0);
        check({tag, "_bus_dv"}, 32'(o_bus_DV), 0);
        check({tag, "_m0_dv"}, 32'(o_m0_DV), 0);
        check({tag, "_m1_dv"}, 32'(o_m1_DV), 0);
        check({tag, "_owner"}, 32'(o_owner), 0);
        check({tag, "_perr"}, 32'(o_protocol_err), 0);
        check({tag, "_stray"}, 32'(o_stray_resp), 0);
        check({tag, "_addr"}, o_bus_address, 0);
        check({tag, "_m0_data"}, o_m0_data, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        i_rst_n = 0; i_m0_DV = 0; i_m1_DV = 0; i_bus_DV = 0;
        i_m0_address = 0; i_m0_data = 0; i_m0_bhw = 0; i_m0_write_notread = 0;
        i_m1_address = 0; i_m1_data = 0; i_m1_bhw = 0; i_m1_write_notread = 0;
        i_bus_data = 0;
        edge_n = 0; done_edge = 0; iss_edge = 0; exp_edge = -1; k_cur = 0;
        auto_sl = 0; dir_k = 1; dir_data = 0;
        model_reset();
        #2;
        check_zero("rst");
        repeat (3) cyc();
        i_rst_n = 1; done_edge = edge_n;
        cyc();

        // 1: single read, slave answers 3 cycles after o_bus_DV
        dir_k = 3; dir_data = 32'h12345678;
        req(0, 32'h100, 32'h0, BHW_WORD, 0);
        drain(30);

        // 2: simultaneous requests, twice
        dir_k = 1; dir_data = 32'h0BAD_F00D;
        req(0, 32'h110, 32'h1, BHW_BYTE, 0);
        req(1, 32'h210, 32'h2, BHW_HALF, 0);
        drain(40);
        req(0, 32'h120, 32'h3, BHW_WORD, 1);
        req(1, 32'h220, 32'h4, BHW_WORD, 1);
        drain(40);

        // 3: M1 write held stable until slave DV
        dir_k = 3; dir_data = 32'h0;
        req(1, 32'h200, 32'hA5A5A5A5, BHW_WORD, 1);
        drain(30);

        // 4: silent slave -> timeout, then late slave DV
        dir_k = 0;
        req(0, 32'h300, 32'h0, BHW_WORD, 0);
        drain(40);
        check("stray_before", 32'(o_stray_resp), 0);
        i_bus_DV = 1; i_bus_data = 32'h5555_5555; stray_m = 1;
        cyc();
        check("stray_after", 32'(o_stray_resp), 32'(stray_m));

        // 5: double pulse from M0 -> protocol error, one response
        dir_k = 4; dir_data = 32'hCAFE_0005;
        req(0, 32'h400, 32'h0, BHW_WORD, 0);
        cyc();
        req(0, 32'h404, 32'h0, BHW_WORD, 0);
        cyc();
        check("perr", 32'(o_protocol_err), 32'(perr_m));
        drain(30);

        // 6: reset in WAIT aborts everything
        dir_k = 0;
        req(0, 32'h500, 32'h0, BHW_WORD, 0);
        repeat (4) cyc();
        check("wait_busy", 32'(o_busy), 1);
        #2;
        i_rst_n = 0;
        #1;
        check_zero("arst");
        model_reset();
        repeat (2) cyc();
        i_rst_n = 1; done_edge = edge_n;
        repeat (T + 5) cyc();
        dir_k = 2; dir_data = 32'h6666_0006;
        req(0, 32'h600, 32'h0, BHW_WORD, 0);
        drain(30);

        // random traffic against the model
        auto_sl = 1;
        repeat (400) begin
            cyc();
            for (int m = 0; m < 2; m++)
                if (!pend[m] && $urandom_range(0, 3) == 0)
                    req(m, $urandom, $urandom, 3'($urandom_range(0, 2)),
                        1'($urandom_range(0, 1)));
        end
        drain(200);
        check("final_perr", 32'(o_protocol_err), 32'(perr_m));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
